// File: rtl/cnn_img_loader.sv
// cnn_img_loader
// Upstream feeder for top_cnn: accepts a serial pixel stream over valid/ready,
// packs one frame into a wide image vector, fires a one-cycle start pulse,
// waits for the inference to finish and registers the prediction.
// Optional build macro: LOADER_TIMEOUT_EN adds an inference watchdog that
// returns 32'hFFFF_FFFF and raises frame_err if top_cnn never answers.
module cnn_img_loader #(
    parameter int PIX_W          = 8,
    parameter int NUM_PIX        = 144,
    parameter int IMG_W          = PIX_W * NUM_PIX,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic [IMG_W-1:0] img_out,
    output logic             img_valid,
    input  logic             cnn_ready,
    input  logic [31:0]      cnn_predict,
    output logic [31:0]      result,
    output logic             result_valid,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(NUM_PIX);
    localparam int IDX_W = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [IMG_W-1:0]   img_q, img_d;
    logic               s_ready_q, s_ready_d;
    logic               img_valid_q, img_valid_d;
    logic [31:0]        result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [IDX_W-1:0]   wr_base;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

    // A watchdog limit below one cycle has no meaning; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("cnn_img_loader: TIMEOUT_CYCLES must be >= 1");
    end

    // Next-state, packing and strobe logic; strobes default low every cycle.
    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        img_d          = img_q;
        img_valid_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        wr_base        = IDX_W'(pix_cnt_q) * IDX_W'(PIX_W);
`ifdef LOADER_TIMEOUT_EN
        to_cnt_d       = '0;
`endif
        case (state_q)
            ST_LOAD: begin
                // s_ready_q is only ever high in LOAD, so this is the transfer
                if (s_valid && s_ready_q) begin
                    img_d[wr_base +: PIX_W] = s_data;
                    if (pix_cnt_q == LAST_IDX) begin
                        pix_cnt_d = '0;
                        if (s_last) begin
                            state_d     = ST_FIRE;
                            img_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // short frame: restart packing, leave stale pixels in place
                        pix_cnt_d   = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // a ready level already present on entry counts as completion
                if (cnn_ready) begin
                    result_d       = cnn_predict;
                    result_valid_d = 1'b1;
                    pix_cnt_d      = '0;
                    state_d        = ST_LOAD;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    result_d       = 32'hFFFF_FFFF;
                    result_valid_d = 1'b1;
                    frame_err_d    = 1'b1;
                    pix_cnt_d      = '0;
                    state_d        = ST_LOAD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = ST_LOAD;
                pix_cnt_d = '0;
            end
        endcase
        s_ready_d = (state_d == ST_LOAD);
    end

    // State, image and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_LOAD;
            pix_cnt_q      <= '0;
            img_q          <= '0;
            s_ready_q      <= 1'b0;
            img_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            img_q          <= img_d;
            s_ready_q      <= s_ready_d;
            img_valid_q    <= img_valid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Watchdog counter: counts WAIT cycles, cleared everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign s_ready      = s_ready_q;
    assign img_out      = img_q;
    assign img_valid    = img_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;

endmodule
